maxpool_ctrl: RTL

MAXPOOL_CTRL -- requirements
Module: maxpool_ctrl

---
 rtl/maxpool_pkg.sv | 17 +
 rtl/pool_max4.sv | 23 ++
 rtl/maxpool_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/maxpool_pkg.sv
// Shared definitions for the 2x2 max-pooling controller: default geometry and FSM encoding.
package maxpool_pkg;

  localparam int DEF_DATA_W = 5;
  localparam int DEF_IMG_W  = 8;
  localparam int DEF_IMG_H  = 8;
  localparam int DEF_ADDR_W = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CMP   = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/pool_max4.sv
// Combinational unsigned maximum of four pixels, used as the compare datapath.
module pool_max4
  import maxpool_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0] m_ab;
  logic [DATA_W-1:0] m_cd;

  always_comb begin
    m_ab = (a > b) ? a : b;
    m_cd = (c > d) ? c : d;
    y    = (m_ab > m_cd) ? m_ab : m_cd;
  end

endmodule

// File: rtl/maxpool_ctrl.sv
// 2x2 stride-2 max-pooling controller: walks a row-major feature map in memory,
// fetches each window, and hands out one pooled pixel per valid/ready handshake.
module maxpool_ctrl
  import maxpool_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              busy,
  output logic              maxPoolingDone
);

  localparam logic [ADDR_W-1:0] ROW1    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW2    = ADDR_W'(2 * IMG_W);
  localparam logic [ADDR_W-1:0] WC_LAST = ADDR_W'(IMG_W / 2 - 1);
  localparam logic [ADDR_W-1:0] WR_LAST = ADDR_W'(IMG_H / 2 - 1);

  state_t            state;
  state_t            state_nx;
  logic [1:0]        cnt;
  logic              vld_p1;
  logic [1:0]        sel_p1;
  logic [DATA_W-1:0] win [4];
  logic [DATA_W-1:0] win_max;
  logic [ADDR_W-1:0] wr;
  logic [ADDR_W-1:0] wc;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] offs;
  logic              hs;
  logic              last_win;

  assign hs       = out_valid && out_ready;
  assign last_win = (wr == WR_LAST) && (wc == WC_LAST);

  pool_max4 #(.DATA_W(DATA_W)) u_max (
    .a (win[0]),
    .b (win[1]),
    .c (win[2]),
    .d (win[3]),
    .y (win_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // CMP holds until the read issued in the last FETCH cycle has been captured.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: if (cnt == 2'd3) state_nx = S_CMP;
      S_CMP:   if (!vld_p1) state_nx = S_OUT;
      S_OUT:   if (hs) state_nx = last_win ? S_DONE : S_FETCH;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    base           = ROW2 * wr + (wc << 1);
    offs           = (cnt[1] ? ROW1 : '0) + ADDR_W'(cnt[0]);
    mem_addr       = base + offs;
    mem_rd_en      = (state == S_FETCH);
    busy           = (state != S_IDLE);
    maxPoolingDone = (state == S_DONE);
  end

  // p1: read data arrives one cycle after its strobe and lands in the slot it was issued for
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 2'd0;
      vld_p1    <= 1'b0;
      sel_p1    <= 2'd0;
      for (int i = 0; i < 4; i++) win[i] <= '0;
      wr        <= '0;
      wc        <= '0;
      out_idx   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      cnt    <= (state == S_FETCH) ? cnt + 2'd1 : 2'd0;
      vld_p1 <= mem_rd_en;
      sel_p1 <= cnt;
      if (vld_p1) win[sel_p1] <= mem_rdata;
      if (state == S_IDLE && start) begin
        wr      <= '0;
        wc      <= '0;
        out_idx <= '0;
      end
      if (state == S_CMP && !vld_p1) begin
        out_data  <= win_max;
        out_valid <= 1'b1;
      end
      if (state == S_OUT && hs) begin
        out_valid <= 1'b0;
        out_idx   <= out_idx + ADDR_W'(1);
        if (wc == WC_LAST) begin
          wc <= '0;
          wr <= wr + ADDR_W'(1);
        end else begin
          wc <= wc + ADDR_W'(1);
        end
      end
    end
  end

endmodule
